inst_fetch_unit: RTL

- Fetch-side initiator for the 32-word instruction ROM.
- Owns the PC and drives the ROM word address (Addr[6:2] selects one of 32 words).
- Captures the returned instruction into an IF/ID pipeline register.
- Redirects the PC for branch, jump, exception entry and exception return. Sits between the ROM and the decode stage of the exception/interrupt-capable CPU.

---
 rtl/inst_fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Fetch stage for a 32-word instruction ROM. Owns the PC, drives the ROM
//   address, captures the returned word into the IF/ID register and
//   redirects the PC on exception entry, exception return, taken branch and
//   jump. Each redirect costs exactly one bubble.
//
// Optional build macro: FETCH_RANGE_CHECK_EN
//   Defined   : a sequential fetch with PC[31:7] != 0 injects a bubble,
//               raises if_fault and holds the PC until a redirect.
//   Undefined : no check; the ROM aliases on Addr[6:2]; if_fault reads 0.
//
// Ports
//   Clk, Clrn          rising-edge clock, synchronous active-low reset
//   Inst               ROM data for Addr (combinational, same cycle)
//   Addr               fetch address, always the PC register
//   stall              decode cannot accept; hold PC and IF/ID
//   br_taken/br_target taken branch and its target
//   jmp/jmp_target     jump and its target
//   exc_req            exception/interrupt accepted; vector to EXC_VECTOR
//   eret/epc_in        return from exception to epc_in
//   id_inst/id_pc4     IF/ID instruction and its PC+4
//   id_valid           IF/ID holds a real instruction
//   epc_out            PC of the instruction in IF/ID (PC itself on a bubble)
//   if_fault           fetch address fault (range-check builds only)
//
// Per-cycle action (no multi-cycle state)
//   action    | meaning
//   ACT_RUN   | sequential fetch, PC += 4, capture Inst into IF/ID
//   ACT_HOLD  | stall, PC and IF/ID unchanged
//   ACT_FLUSH | redirect, PC <= aligned target, IF/ID becomes a bubble
//   ACT_FAULT | out-of-range fetch, bubble, PC holds, if_fault set
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc_in,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] epc_out,
    output logic        if_fault
);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_FAULT
    } act_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    act_e        act;
    logic [31:0] redir_target;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // Priority: exception > eret > branch > jump > stall > fetch.
    // Branch beats jump because the branch belongs to the older instruction.
    always_comb begin
        act          = ACT_RUN;
        redir_target = pc_q;
        if (exc_req) begin
            act          = ACT_FLUSH;
            redir_target = EXC_VECTOR;
        end else if (eret) begin
            act          = ACT_FLUSH;
            redir_target = epc_in;
        end else if (br_taken) begin
            act          = ACT_FLUSH;
            redir_target = br_target;
        end else if (jmp) begin
            act          = ACT_FLUSH;
            redir_target = jmp_target;
        end else if (stall) begin
            act = ACT_HOLD;
        end
`ifdef FETCH_RANGE_CHECK_EN
        else if (pc_q[31:7] != 25'd0) begin
            act = ACT_FAULT;
        end
`endif
    end

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (act)
            ACT_RUN: begin
                pc_d    = pc_plus4;
                inst_d  = Inst;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                fault_d = 1'b0;
            end
            ACT_FLUSH: begin
                // Targets are word aligned regardless of source.
                pc_d    = {redir_target[31:2], 2'b00};
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
            ACT_FAULT: begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign Addr     = pc_q;
    assign id_inst  = inst_q;
    assign id_pc4   = pc4_q;
    assign id_valid = valid_q;
    // A bubble has no instruction of its own, so report the next-fetch PC.
    assign epc_out  = valid_q ? (pc4_q - 32'd4) : pc_q;
    assign if_fault = fault_q;

endmodule
